// File: rtl/seven_seg_scan_driver.sv
// Purpose : time-multiplexes a 28-bit active-low segment word onto a 4-digit common-anode display.
// Latency : outputs registered, one cycle behind the scan counters; a captured frame shows on each digit after its blank.
// Backpres: none; Enable low blanks the display and parks the scan at its start point, frame is kept.
module seven_seg_scan_driver #(
    parameter int SLOT_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Enable,
    input  logic [27:0] Seven_seg,
    output logic [6:0]  Seg_n,
    output logic [3:0]  Digit_n,
    output logic [1:0]  Digit_idx,
    output logic        Frame_start
);

    localparam int CNT_W = $clog2(SLOT_CYCLES);
    localparam logic [CNT_W-1:0] SLOT_MAX  = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

    // Slot phase is a pure function of the slot counter: blank first, then lit.
    typedef enum logic {
        PH_BLANK,
        PH_ON
    } phase_t;

    logic [CNT_W-1:0] slot_cnt;
    logic [CNT_W-1:0] slot_cnt_nxt;
    logic [1:0]       digit;
    logic [1:0]       digit_nxt;
    logic [3:0][6:0]  frame;
    logic [3:0][6:0]  frame_nxt;
    logic [6:0]       seg_nxt;
    logic [3:0]       digit_sel_nxt;
    logic             frame_start_nxt;
    logic             slot_end;
    logic             frame_top;
    phase_t           phase;

    // Decode where we are in the slot and in the frame.
    always_comb begin
        slot_end  = (slot_cnt == SLOT_MAX);
        frame_top = (slot_cnt == '0) && (digit == 2'd0);
        phase     = (slot_cnt < BLANK_END) ? PH_BLANK : PH_ON;
    end

    // Next-state and next-output logic, evaluated from the pre-edge state.
    always_comb begin
        slot_cnt_nxt    = slot_cnt;
        digit_nxt       = digit;
        frame_nxt       = frame;
        seg_nxt         = 7'h7F;
        digit_sel_nxt   = 4'hF;
        frame_start_nxt = 1'b0;
        if (!Enable) begin
            // Park at the frame start so re-enabling captures immediately.
            slot_cnt_nxt = '0;
            digit_nxt    = 2'd0;
        end else begin
            frame_start_nxt = frame_top;
            if (frame_top) begin
                frame_nxt = Seven_seg;
            end
            if (phase == PH_ON) begin
                digit_sel_nxt = ~(4'b0001 << digit);
                seg_nxt       = frame[digit];
            end
            if (slot_end) begin
                slot_cnt_nxt = '0;
                digit_nxt    = digit + 2'd1;
            end else begin
                slot_cnt_nxt = slot_cnt + CNT_W'(1);
            end
        end
    end

    // State and output registers; reset overrides everything, including Enable.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            slot_cnt    <= '0;
            digit       <= 2'd0;
            frame       <= 28'hFFFFFFF;
            Seg_n       <= 7'h7F;
            Digit_n     <= 4'hF;
            Digit_idx   <= 2'd0;
            Frame_start <= 1'b0;
        end else begin
            slot_cnt    <= slot_cnt_nxt;
            digit       <= digit_nxt;
            frame       <= frame_nxt;
            Seg_n       <= seg_nxt;
            Digit_n     <= digit_sel_nxt;
            Digit_idx   <= digit;
            Frame_start <= frame_start_nxt;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver with an 8-cycle slot and 2-cycle blank.
// Reference model tracks a single frame-relative time index and a latched frame.
// Directed scenarios pin the model with literal values; a random run follows.
module tb_seven_seg_scan_driver;

    localparam int SLOT  = 8;
    localparam int BLANK = 2;
    localparam int PER   = 4 * SLOT;
    localparam logic [27:0] PAT = {7'h40, 7'h79, 7'h24, 7'h30};

    logic        Clk;
    logic        Rst;
    logic        Enable;
    logic [27:0] Seven_seg;
    logic [6:0]  Seg_n;
    logic [3:0]  Digit_n;
    logic [1:0]  Digit_idx;
    logic        Frame_start;

    int checks   = 0;
    int failures = 0;

    seven_seg_scan_driver #(
        .SLOT_CYCLES (SLOT),
        .BLANK_CYCLES(BLANK)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Enable     (Enable),
        .Seven_seg  (Seven_seg),
        .Seg_n      (Seg_n),
        .Digit_n    (Digit_n),
        .Digit_idx  (Digit_idx),
        .Frame_start(Frame_start)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Reference model: t counts enabled edges since the last frame start.
    int          t = 0;
    int          s_m;
    int          k_m;
    logic [27:0] mframe = 28'hFFFFFFF;
    logic [3:0]  exp_dn;
    logic [6:0]  exp_sn;
    logic [1:0]  exp_idx;
    logic        exp_fs;
    int          last_dig = -1;
    int          blank_run = 0;
    int          cur_dig;

    always @(posedge Clk) begin
        exp_dn = 4'hF;
        exp_sn = 7'h7F;
        exp_fs = 1'b0;
        if (Rst) begin
            exp_idx = 2'd0;
            t       = 0;
            mframe  = 28'hFFFFFFF;
        end else if (!Enable) begin
            exp_idx = 2'((t / SLOT) % 4);
            t       = 0;
        end else begin
            s_m     = (t / SLOT) % 4;
            k_m     = t % SLOT;
            exp_idx = 2'(s_m);
            exp_fs  = (t == 0);
            if (k_m >= BLANK) begin
                exp_dn[s_m] = 1'b0;
                exp_sn      = mframe[7*s_m +: 7];
            end
            if (t == 0) mframe = Seven_seg;
            t = (t + 1) % PER;
        end
        #1;
        chk("model_digit_n", 32'(Digit_n), 32'(exp_dn));
        chk("model_seg_n", 32'(Seg_n), 32'(exp_sn));
        chk("model_digit_idx", 32'(Digit_idx), 32'(exp_idx));
        chk("model_frame_start", 32'(Frame_start), 32'(exp_fs));
        // Display-level invariants: one-cold select and a blank gap between digits.
        chk("inv_onecold", 32'(Digit_n inside {4'hF, 4'hE, 4'hD, 4'hB, 4'h7}), 32'd1);
        if (Digit_n === 4'hF) begin
            blank_run++;
        end else begin
            cur_dig = -1;
            for (int i = 0; i < 4; i++) if (Digit_n[i] === 1'b0) cur_dig = i;
            if (last_dig >= 0 && cur_dig != last_dig)
                chk("inv_blank_gap", 32'(blank_run >= BLANK), 32'd1);
            last_dig  = cur_dig;
            blank_run = 0;
        end
    end

    task automatic step(input logic r, input logic e, input logic [27:0] sv);
        Rst       = r;
        Enable    = e;
        Seven_seg = sv;
        @(posedge Clk);
        #2;
    endtask

    task automatic pin(input string name, input logic [3:0] dn, input logic [6:0] sn, input logic fs);
        chk({name, "_digit_n"}, 32'(Digit_n), 32'(dn));
        chk({name, "_seg_n"}, 32'(Seg_n), 32'(sn));
        chk({name, "_frame_start"}, 32'(Frame_start), 32'(fs));
    endtask

    logic [27:0] rnd_seg;
    logic        rnd_rst;
    logic        rnd_en;

    initial begin
        Rst       = 1'b1;
        Enable    = 1'b1;
        Seven_seg = 28'h0;

        // Reset values held over three cycles.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 28'h0);
            pin("s1_reset", 4'hF, 7'h7F, 1'b0);
            chk("s1_reset_idx", 32'(Digit_idx), 32'd0);
        end

        // Scan order, then frame coherence with the input cleared from edge 5.
        for (int e = 0; e <= 34; e++) begin
            step(1'b0, 1'b1, (e < 5) ? PAT : 28'h0);
            case (e)
                0:  pin("s2_e0", 4'hF, 7'h7F, 1'b1);
                1:  pin("s2_e1", 4'hF, 7'h7F, 1'b0);
                2:  pin("s2_e2", 4'hE, 7'h30, 1'b0);
                7:  pin("s3_e7_old", 4'hE, 7'h30, 1'b0);
                8:  pin("s2_e8", 4'hF, 7'h7F, 1'b0);
                10: pin("s3_e10_d1", 4'hD, 7'h24, 1'b0);
                15: pin("s2_e15", 4'hD, 7'h24, 1'b0);
                18: pin("s3_e18_d2", 4'hB, 7'h79, 1'b0);
                26: pin("s3_e26_d3", 4'h7, 7'h40, 1'b0);
                31: pin("s2_e31", 4'h7, 7'h40, 1'b0);
                32: pin("s2_e32", 4'hF, 7'h7F, 1'b1);
                34: pin("s3_e34_new", 4'hE, 7'h00, 1'b0);
                default: ;
            endcase
        end

        // Enable dropped for edges 12..19, raised again at edge 20.
        step(1'b1, 1'b1, PAT);
        for (int e = 0; e <= 27; e++) begin
            step(1'b0, !(e >= 12 && e < 20), PAT);
            case (e)
                11: pin("s4_e11", 4'hD, 7'h24, 1'b0);
                12: pin("s4_e12", 4'hF, 7'h7F, 1'b0);
                19: pin("s4_e19", 4'hF, 7'h7F, 1'b0);
                20: pin("s4_e20", 4'hF, 7'h7F, 1'b1);
                21: pin("s4_e21", 4'hF, 7'h7F, 1'b0);
                22: begin
                    pin("s4_e22", 4'hE, 7'h30, 1'b0);
                    chk("s4_e22_idx", 32'(Digit_idx), 32'd0);
                end
                27: pin("s4_e27", 4'hE, 7'h30, 1'b0);
                default: ;
            endcase
        end

        // Reset while digit 1 is lit, then the start sequence again.
        step(1'b1, 1'b1, PAT);
        for (int e = 0; e <= 12; e++) step(1'b0, 1'b1, PAT);
        pin("s5_e12", 4'hD, 7'h24, 1'b0);
        step(1'b1, 1'b1, PAT);
        pin("s5_rst", 4'hF, 7'h7F, 1'b0);
        chk("s5_rst_idx", 32'(Digit_idx), 32'd0);
        for (int e = 0; e <= 2; e++) begin
            step(1'b0, 1'b1, PAT);
            if (e == 0) pin("s5_e0", 4'hF, 7'h7F, 1'b1);
            if (e == 2) pin("s5_e2", 4'hE, 7'h30, 1'b0);
        end

        // Random segment words, occasional Enable drops and rare resets.
        for (int i = 0; i < 1000; i++) begin
            rnd_seg = 28'($urandom);
            rnd_rst = ($urandom_range(0, 199) == 0);
            rnd_en  = ($urandom_range(0, 24) != 0);
            step(rnd_rst, rnd_en, rnd_seg);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_driver.md
# seven_seg_scan_driver

Display-side end of the core's `Seven_seg` bus. It takes the 28-bit parallel, active-low segment word (4 digits × 7 segments) produced by `MSP430x2xx_block_diagram` and drives a time-multiplexed 4-digit common-anode display. Only 7 segment lines and 4 digit-select lines leave the chip. The block captures one coherent frame per refresh period, scans the digits in a fixed order, and inserts a blanking interval before each digit to suppress ghosting. It sits beside the core at the board top level, between `Seven_seg` and the display pins.

## Interface
Parameters:
- `SLOT_CYCLES`, default 50000: clock cycles per digit slot (1 ms at 50 MHz, so the full frame refreshes at 250 Hz). Must be ≥ 2.
- `BLANK_CYCLES`, default 1000: blank cycles at the start of each slot. Must satisfy 1 ≤ `BLANK_CYCLES` < `SLOT_CYCLES`.

Ports:
- `Clk` input 1: system clock. Single clock domain; every register in the block is clocked by it.
- `Rst` input 1: reset, synchronous, active-high.
- `Enable` input 1: when high, scanning runs. When low, the display is blanked and scanning is held at its start point.
- `Seven_seg` input 28: segment word, active-low. Digit i occupies bits [7i+6:7i]. Within each digit the order is {g,f,e,d,c,b,a}, with a at the LSB. Digit 0 is the rightmost.
- `Seg_n` output 7: segment cathodes, active-low, same {g..a} order as the input.
- `Digit_n` output 4: digit anode selects, active-low, one-cold. Bit i selects digit i.
- `Digit_idx` output 2: index of the digit currently owning the slot (for debug).
- `Frame_start` output 1: one-cycle pulse that fires when a new frame is captured.

## Operation
Internal state:
- `slot_cnt`, range 0..`SLOT_CYCLES`−1.
- `digit`, 2 bits.
- `frame`, 28 bits.

Counting:
- When `Enable` is high, `slot_cnt` increments on every edge.
- At `SLOT_CYCLES`−1, `slot_cnt` wraps to 0 and `digit` increments. `digit` wraps from 3 to 0.

Frame capture:
- At any edge where `Enable` is high, `slot_cnt` is 0 and `digit` is 0, the block loads `frame` from `Seven_seg`.
- Changes on `Seven_seg` at any other time are not displayed until the next capture. No tearing within a frame.

Per-slot FSM, derived from `slot_cnt`:
- BLANK while `slot_cnt` < `BLANK_CYCLES`: `Digit_n` = 4'hF, `Seg_n` = 7'h7F.
- ON otherwise: `Digit_n` has only bit `digit` low, and `Seg_n` = `frame`[7·`digit`+6 : 7·`digit`].
- Transitions: BLANK→ON when `slot_cnt` reaches `BLANK_CYCLES`. ON→BLANK on slot wrap.

Outputs:
- All outputs are registered. They are computed from the pre-edge state and `Enable`, so they lag the counter state by one cycle.
- `Digit_idx` mirrors `digit` with the same one-cycle lag.

Enable low:
- On the edge where `Enable` is sampled low, outputs go blank (`Digit_n` = F, `Seg_n` = 7F) and `slot_cnt` and `digit` are forced to 0.
- `frame` is retained.
- On the first edge with `Enable` high again, a capture occurs immediately.

Reset (synchronous, applies at any point, including mid-slot or mid-frame):
- `slot_cnt` = 0, `digit` = 0, `frame` = 28'hFFFFFFF (all segments off).
- Reset values of outputs: `Digit_n` = 4'hF, `Seg_n` = 7'h7F, `Digit_idx` = 0, `Frame_start` = 0.
- `Rst` has priority over `Enable`.

## Timing
- Edge numbering: edge 0 is the first edge with `Rst` = 0 and `Enable` = 1.
- Capture happens at edge 0. `Frame_start` is high only after edge 0, then again after edge 4·`SLOT_CYCLES`, and so on.
- Display period is 4·`SLOT_CYCLES` cycles.
- After edges s·`SLOT_CYCLES` + k, for slot s = 0..3:
  - blank when k < `BLANK_CYCLES`;
  - digit s driven for the remaining `SLOT_CYCLES`−`BLANK_CYCLES` cycles.
- Latency: a `Seven_seg` change just before a capture edge is visible on `Seg_n` at the first ON cycle of the matching digit. For digit 0 that is after edge `BLANK_CYCLES`.
- At no cycle is more than one `Digit_n` bit low.
- At no cycle does `Digit_n` change directly from one digit to another without at least `BLANK_CYCLES` all-off cycles in between.

## Test plan
All scenarios use `SLOT_CYCLES` = 8 and `BLANK_CYCLES` = 2.
1. Reset values:
   - Stimulus: hold `Rst` high for 3 cycles with `Enable` = 1 and `Seven_seg` = 0.
   - Required: `Digit_n` = F, `Seg_n` = 7F, `Frame_start` = 0, `Digit_idx` = 0 throughout.
2. Scan order:
   - Stimulus: `Seven_seg` = {7'h40, 7'h79, 7'h24, 7'h30} (digit 3 down to digit 0), then release `Rst`.
   - Required after edges 0–1: blank. After edges 2–7: `Digit_n` = E, `Seg_n` = 30. After edges 8–9: blank. After edges 10–15: D/24. Then B/79, then 7/40. `Frame_start` high only after edges 0 and 32.
3. Frame coherence:
   - Stimulus: change `Seven_seg` to all 0 at edge 5.
   - Required: digits 1–3 still show the old values. Digit 0 shows `Seg_n` = 00 only after edge 34.
4. Enable drop mid-slot:
   - Stimulus: drop `Enable` at edge 12 and re-raise it at edge 20.
   - Required: blank after edge 12 through edge 20. `Frame_start` high after edge 20. Digit 0 (`Digit_n` = E) after edges 22–27.
5. Reset mid-ON:
   - Stimulus: assert `Rst` at edge 13.
   - Required: `Digit_n` = F and `Seg_n` = 7F after edge 13. After release, the edge-0 sequence of scenario 2 restarts.
6. Invariants, checked over 1000 cycles of random `Seven_seg` and `Enable`:
   - `Digit_n` is always one-cold or F.
   - ≥ 2 blank cycles between any two different digits.
